// File: rtl/seven_segment_scan.sv
// seven_segment_scan: round-robin hex display scanner with dead time, frame-synchronous
// double buffering and optional leading-zero blanking.
module seven_segment_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int DIGIT_CYCLES   = 1024,
    parameter int DEAD_CYCLES    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    blank_lz,
    output logic [6:0]              segments,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);
    localparam int PW = $clog2(DIGIT_CYCLES);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam int BW = 5 * NUM_DIGITS;
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [PW-1:0]         p_q, p_d;
    logic [DW-1:0]         d_q, d_d;
    logic [BW-1:0]         pending_q, pending_d, display_q, display_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] dig_q, dig_d;
    logic                  fd_q, fd_d;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [3:0]            nib;
    logic                  last_p, last_d, boundary, active, blanked;
    always_comb begin
        disp_val  = display_q[BW-1:NUM_DIGITS];
        disp_dp   = display_q[NUM_DIGITS-1:0];
        last_p    = p_q == PW'(DIGIT_CYCLES - 1);
        last_d    = d_q == DW'(NUM_DIGITS - 1);
        boundary  = enable && last_p && last_d;
        p_d       = (enable && !last_p) ? p_q + 1'b1 : '0;
        d_d       = !enable ? '0 : !last_p ? d_q : last_d ? '0 : d_q + 1'b1;
        pending_d = load ? {value_in, dp_in} : pending_q;
        // a load on the boundary cycle goes straight to the display
        display_d = !boundary ? display_q : load ? {value_in, dp_in} : pending_q;
        active    = enable && p_q >= PW'(DEAD_CYCLES);
        nib       = disp_val[{d_q, 2'b00} +: 4];
        blanked   = blank_lz && d_q != '0 && (disp_val >> {d_q, 2'b00}) == '0;
        seg_d     = ((active && !blanked) ? SEG_LUT[nib] : 7'h00) ^ {7{SEG_ACTIVE_LOW}};
        dp_d      = (active && disp_dp[d_q]) ^ SEG_ACTIVE_LOW;
        dig_d     = (active ? NUM_DIGITS'(1) << d_q : '0) ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
        fd_d      = boundary;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q       <= '0;
            d_q       <= '0;
            pending_q <= '0;
            display_q <= '0;
            seg_q     <= {7{SEG_ACTIVE_LOW}};
            dp_q      <= SEG_ACTIVE_LOW;
            dig_q     <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
            fd_q      <= 1'b0;
        end else begin
            p_q       <= p_d;
            d_q       <= d_d;
            pending_q <= pending_d;
            display_q <= display_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_q     <= dig_d;
            fd_q      <= fd_d;
        end
    end
    assign segments   = seg_q;
    assign seg_dp     = dp_q;
    assign digit_sel  = dig_q;
    assign frame_done = fd_q;
endmodule
